// File: rtl/alarm_ctrl.sv
// Alarm time register, time comparator and arm/ring/snooze FSM.
// Define ALARM_SNOOZE_EN to compile in the snooze state and BCD adder.
module alarm_ctrl #(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic [7:0] time_hr,
  input  logic [7:0] time_min,
  input  logic [7:0] time_sec,
  input  logic       set_mode,
  input  logic       inc_hr,
  input  logic       inc_min,
  input  logic       arm,
  input  logic       stop,
  input  logic       snooze,
  output logic [7:0] alarm_hr,
  output logic [7:0] alarm_min,
  output logic       ringing,
  output logic       snooze_active
);

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {
    IDLE, ARMED, RINGING, SNOOZE
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, ARMED, RINGING
  } state_t;
`endif

  localparam logic [8:0] RING_LIM = 9'(RING_SECS);

  state_t     state, state_n;
  logic [7:0] hr_q, min_q, cnt_q;
  logic [7:0] tgt_hr, tgt_min;
  logic       match, match_q, trigger, valid, timeout;

  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v,
    input logic [7:0] max
  );
    if (v == max) return 8'h00;
    if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

`ifdef ALARM_SNOOZE_EN
  logic [7:0] snz_hr, snz_min, snz_hr_n, snz_min_n;
  logic [6:0] m_bin, m_sum, m_nxt;
  logic [4:0] h_bin, h_nxt;
  logic       carry;

  // Snooze target: current hh:mm plus SNOOZE_MIN, minute carries into hour
  always_comb begin
    m_bin = 7'(time_min[7:4]) * 7'd10 + 7'(time_min[3:0]);
    h_bin = 5'(time_hr[7:4]) * 5'd10 + 5'(time_hr[3:0]);
    m_sum = m_bin + 7'(SNOOZE_MIN);
    carry = m_sum >= 7'd60;
    m_nxt = carry ? m_sum - 7'd60 : m_sum;
    h_nxt = h_bin;
    if (carry) h_nxt = (h_bin == 5'd23) ? 5'd0 : h_bin + 5'd1;
    snz_min_n = {4'(m_nxt / 7'd10), 4'(m_nxt % 7'd10)};
    snz_hr_n  = {4'(h_nxt / 5'd10), 4'(h_nxt % 5'd10)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snz_hr  <= 8'h00;
      snz_min <= 8'h00;
    end else if (state == RINGING && arm && !stop && snooze) begin
      snz_hr  <= snz_hr_n;
      snz_min <= snz_min_n;
    end
  end
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  always_comb begin
    tgt_hr  = hr_q;
    tgt_min = min_q;
`ifdef ALARM_SNOOZE_EN
    if (state == SNOOZE) begin
      tgt_hr  = snz_hr;
      tgt_min = snz_min;
    end
`endif
    valid = time_hr[7:4] <= 4'd9 && time_hr[3:0] <= 4'd9 &&
            time_min[7:4] <= 4'd9 && time_min[3:0] <= 4'd9 &&
            time_sec[7:4] <= 4'd9 && time_sec[3:0] <= 4'd9;
    match = valid && time_hr == tgt_hr &&
            time_min == tgt_min && time_sec == 8'h00;
    trigger = match && !match_q;
    timeout = sec_tick && ({1'b0, cnt_q} + 9'd1 == RING_LIM);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!arm) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:  state_n = ARMED;
        ARMED: if (trigger) state_n = RINGING;
        RINGING: begin
          if (stop) state_n = ARMED;
`ifdef ALARM_SNOOZE_EN
          else if (snooze) state_n = SNOOZE;
`endif
          else if (timeout) state_n = ARMED;
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (stop) state_n = ARMED;
          else if (trigger) state_n = RINGING;
        end
`endif
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    ringing       = state == RINGING;
    snooze_active = 1'b0;
`ifdef ALARM_SNOOZE_EN
    snooze_active = state == SNOOZE;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hr_q    <= 8'h06;
      min_q   <= 8'h00;
      cnt_q   <= 8'd0;
      match_q <= 1'b0;
    end else begin
      match_q <= match;
      if (set_mode && (state == IDLE || state == ARMED)) begin
        if (inc_hr)  hr_q  <= bcd_inc(hr_q, 8'h23);
        if (inc_min) min_q <= bcd_inc(min_q, 8'h59);
      end
      if (state_n == RINGING && state != RINGING) cnt_q <= 8'd0;
      else if (state == RINGING && sec_tick)      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign alarm_hr  = hr_q;
  assign alarm_min = min_q;

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

- Consumes the BCD time-of-day (hh:mm:ss) produced by the clock counter.
- Holds a user-set alarm time in BCD, adjusted with increment pulses.
- Compares the running time against the alarm and drives a `ringing` output through an arm/ring/snooze state machine.
- Its `alarm_hr`/`alarm_min` outputs feed the display mux through the same 7-segment decoders as the time digits.

## Interface
Parameters:
- RING_SECS, 60: seconds of ringing before automatic stop (1..255).
- SNOOZE_MIN, 5: snooze interval in minutes (1..59).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- sec_tick  in  1  one-cycle pulse per elapsed second
- time_hr  in  8  current hour, packed BCD 00..23
- time_min  in  8  current minute, packed BCD 00..59
- time_sec  in  8  current second, packed BCD 00..59
- set_mode  in  1  level; enables alarm adjustment
- inc_hr  in  1  one-cycle pulse; alarm hour +1
- inc_min  in  1  one-cycle pulse; alarm minute +1
- arm  in  1  level; alarm enabled
- stop  in  1  one-cycle pulse; dismiss alarm
- snooze  in  1  one-cycle pulse; request snooze
- alarm_hr  out  8  alarm hour, packed BCD
- alarm_min  out  8  alarm minute, packed BCD
- ringing  out  1  alarm sounding
- snooze_active  out  1  snooze pending

## Operation
- States: IDLE, ARMED, RINGING, SNOOZE.
- Reset values: state IDLE, alarm_hr 8'h06, alarm_min 8'h00, ringing 0, snooze_active 0, ring counter 0, match_q 0.
- Adjust: inc_hr/inc_min act only when set_mode=1 and state is IDLE or ARMED; ignored otherwise.
  - BCD increment: low nibble 9 -> 0 with high nibble +1.
  - Hour wraps 23 -> 00. Minute wraps 59 -> 00 with no carry into the hour.
  - inc_hr and inc_min in the same cycle both apply.
- Match: hr/min equal to the target, time_sec == 8'h00, and every input nibble a valid BCD digit (<= 9).
  - Target is alarm_hr/min in ARMED and snz_hr/min in SNOOZE.
  - match_q registers match each cycle. trigger = match & ~match_q, i.e. it fires only on entry into the matching second.
- IDLE: arm=1 -> ARMED. Arming while the match condition already holds does not ring.
- ARMED: trigger -> RINGING; ring counter cleared.
- RINGING:
  - Ring counter +1 on each sec_tick. When it reaches RING_SECS -> ARMED.
  - stop -> ARMED.
  - snooze -> SNOOZE; snz_hr/min = current time_hr/min + SNOOZE_MIN in BCD, minute overflow carries into the hour, hour wraps 23 -> 00.
- SNOOZE: trigger -> RINGING with ring counter cleared; stop -> ARMED.
- arm=0 in any state -> IDLE next cycle.
- Priority within a cycle: rst > arm=0 > stop > snooze > ring timeout > trigger.
- ringing=1 exactly in RINGING. snooze_active=1 exactly in SNOOZE.

## Timing
- All outputs registered.
- alarm_hr/alarm_min update on the clk edge after the inc pulse.
- ringing rises one cycle after the cycle in which trigger is high.
- ringing falls one cycle after stop, after arm drops, or after the sec_tick that brings the count to RING_SECS.
- rst mid-ring: ringing 0 and alarm time back to 06:00 on the next edge.
- sec_tick is used only for ring duration. Matching is purely on time values.

## Configuration
- ALARM_SNOOZE_EN defined: SNOOZE state, snz_hr/min registers and the BCD adder are compiled in; behaviour as above.
- ALARM_SNOOZE_EN undefined: snooze input ignored, SNOOZE state and registers absent, snooze_active tied 0. In RINGING, a snooze pulse has no effect.

## Test plan
- Reset, then 3 inc_hr + 2 inc_min with set_mode=1 -> alarm 09:02. Inc_min ×60 from 00 -> minute 00, hour unchanged.
- Alarm 06:00, arm=1, drive time 05:59:59 then 06:00:00 -> ringing=1 one cycle later. Holding 06:00:00 produces no re-trigger after stop.
- RING_SECS=3, ringing: 3 sec_ticks -> ringing=0 after the third, state ARMED.
- Ringing at 23:58, snooze (macro on) -> snooze_active=1. Time 00:03:00 -> ringing=1.
- Stop and snooze asserted in the same cycle while ringing -> ringing=0, snooze_active=0.
- arm=1 while time already 06:00:00 -> no ring. Invalid BCD 06:0A:00 -> no ring. arm=0 while ringing -> ringing=0 next cycle.
